simple_cpu_sequencer: RTL and testbench
=======================================

# simple_cpu_sequencer

Program sequencer that feeds `simple_cpu` its instruction stream. Holds a small writable program memory, walks a program counter from a start address, presents each 20-bit instruction to the CPU for a fixed number of cycles, and stops on a HALT word or on abort. Sits between the host/testbench load port and the `instruction` input of `simple_cpu`, replacing hand-driven instruction sequencing.

## Interface
- `INSTR_WIDTH`, 20, instruction word width (matches `simple_cpu`)
- `PROG_ADDR_BITS`, 4, program memory depth = 2**PROG_ADDR_BITS words
- `CYCLES_PER_INSTR`, 4, cycles each instruction is held on `instr_out` (≥1)
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `prog_we` in 1: program memory write strobe (honoured only in IDLE)
- `prog_addr` in PROG_ADDR_BITS: write address
- `prog_wdata` in INSTR_WIDTH: write data
- `start` in 1: begin run at `start_addr` (honoured only in IDLE)
- `start_addr` in PROG_ADDR_BITS: first PC of run
- `abort` in 1: terminate run, return to IDLE
- `instr_out` out INSTR_WIDTH: instruction to `simple_cpu`
- `instr_valid` out 1: high while `instr_out` carries a live instruction
- `busy` out 1: high in FETCH and ISSUE
- `done` out 1: one-cycle pulse on HALT completion
- `pc` out PROG_ADDR_BITS: current program counter
- `retired` out 8: instructions issued in current/last run, saturating at 255

## Operation
- Instruction type field [19:18]: 00 HALT, 01 ALU (bit0: 0 ADD, 1 SUB), 10 LOAD, 11 STORE. Type 00 is a no-op for `simple_cpu`; all-zero is the idle bus value.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE: `instr_out`=0, `instr_valid`=0, `busy`=0. `start`&!`abort` → load `pc`←`start_addr`, clear `retired`, go FETCH. `prog_we` writes memory here only.
- FETCH: one cycle, synchronous memory read at `pc`; `instr_out`=0. Next: word type 00 → DONE; else → ISSUE.
- ISSUE: `instr_out`=fetched word, `instr_valid`=1 for exactly CYCLES_PER_INSTR cycles; `retired` increments (saturating) on entry. On last cycle `pc`←`pc`+1 mod 2**PROG_ADDR_BITS, go FETCH.
- DONE: `done`=1 for one cycle, `pc` holds HALT address, → IDLE.
- `abort` in any non-IDLE state: next edge → IDLE, `instr_out` cleared, no `done`; `pc`, `retired` hold.
- `start` while busy ignored; `prog_we` while not IDLE ignored (memory unchanged).
- `start`&`abort` same cycle in IDLE: stay IDLE.
- No HALT in memory: run loops forever with PC wrap until abort.

## Timing
- Reset (async, immediate): state IDLE, `pc`=0, `retired`=0, `instr_out`=0, `instr_valid`=0, `busy`=0, `done`=0. Memory contents not reset.
- `start` sampled at edge 0: FETCH cycle 1, first instruction on `instr_out` cycles 2..1+N (N=CYCLES_PER_INSTR).
- Instruction k (0-based) valid cycles 2+k(N+1) .. 1+N+k(N+1); one zero bubble between instructions.
- HALT at position h: FETCH at cycle 1+h(N+1), `done` at 2+h(N+1), IDLE next cycle.
- All outputs registered; `rst_n` deassertion synchronised externally.

## Structure
- Package `simple_cpu_pkg`: state enum, instruction type constants (TYPE_HALT/ALU/LOAD/STORE), field bit positions, ALU opcode constants; shared with `simple_cpu`.
- One sub-module `seq_prog_mem`: 2**PROG_ADDR_BITS × INSTR_WIDTH, sync write, registered read.
- FSM, hold counter ($clog2(CYCLES_PER_INSTR+1) bits), PC and retire counter in top.

## Test plan
- Reset: assert `rst_n`=0 mid-ISSUE without clock edge → `instr_out`=0, `busy`=0, `pc`=0 immediately.
- Program 0x47000,0x53000,0x72001,0xD80F0,0xCC160,0xB80F0, HALT(0) at 6; start at 0, N=4 → each word valid 4 cycles with 1-cycle zero gaps, `done` at cycle 32, `retired`=6; attached `simple_cpu` ends with reg3=7.
- Abort during second cycle of instruction 2 → next cycle `instr_out`=0, `busy`=0, no `done`, `retired`=3, `pc`=2.
- Wrap: words 14,15 ALU, word 0 HALT, `start_addr`=14 → issues 14,15, `pc` 15→0, `done`, `retired`=2.
- Ignored inputs: `start` and `prog_we` to addr 1 while busy → run unaffected, addr 1 unchanged on rerun; `start`+`abort` in IDLE → stays IDLE.
- Immediate HALT at `start_addr` → no `instr_valid`, `done` at cycle 2, `retired`=0.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared definitions for simple_cpu and its program sequencer: instruction
// field layout, type and ALU opcode constants, and the sequencer state enum.
package simple_cpu_pkg;

    localparam int unsigned TYPE_MSB   = 19;
    localparam int unsigned TYPE_LSB   = 18;
    localparam int unsigned ALU_OP_BIT = 0;

    localparam logic [1:0] TYPE_HALT  = 2'b00;
    localparam logic [1:0] TYPE_ALU   = 2'b01;
    localparam logic [1:0] TYPE_LOAD  = 2'b10;
    localparam logic [1:0] TYPE_STORE = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StDone
    } seq_state_e;

endpackage

// File: rtl/seq_prog_mem.sv
// Program memory for the sequencer: synchronous write, registered read.
module seq_prog_mem #(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned WIDTH     = 20
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/simple_cpu_sequencer.sv
// Walks a program counter through seq_prog_mem and holds each instruction on
// instr_out for CYCLES_PER_INSTR cycles until a HALT word or abort.
module simple_cpu_sequencer
    import simple_cpu_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH      = 20,
    parameter int unsigned PROG_ADDR_BITS   = 4,
    parameter int unsigned CYCLES_PER_INSTR = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      prog_we,
    input  logic [PROG_ADDR_BITS-1:0] prog_addr,
    input  logic [INSTR_WIDTH-1:0]    prog_wdata,
    input  logic                      start,
    input  logic [PROG_ADDR_BITS-1:0] start_addr,
    input  logic                      abort,
    output logic [INSTR_WIDTH-1:0]    instr_out,
    output logic                      instr_valid,
    output logic                      busy,
    output logic                      done,
    output logic [PROG_ADDR_BITS-1:0] pc,
    output logic [7:0]                retired
);

    localparam int unsigned CNT_W = $clog2(CYCLES_PER_INSTR + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_INSTR - 1);

    seq_state_e                state_q, state_d;
    logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
    logic [7:0]                retired_q, retired_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [INSTR_WIDTH-1:0]    rdata;
    logic                      mem_we;

    assign mem_we = prog_we && (state_q == StIdle);

    // Read address is the next PC so the word is ready during the FETCH cycle.
    seq_prog_mem #(
        .ADDR_BITS (PROG_ADDR_BITS),
        .WIDTH     (INSTR_WIDTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc_d),
        .rdata (rdata)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        cnt_d     = cnt_q;
        instr_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d   = StFetch;
                    pc_d      = start_addr;
                    retired_d = '0;
                end
            end
            StFetch: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (rdata[TYPE_MSB:TYPE_LSB] == TYPE_HALT) begin
                    state_d = StDone;
                end else begin
                    state_d   = StIssue;
                    cnt_d     = '0;
                    instr_d   = rdata;
                    retired_d = (retired_q == 8'hff) ? retired_q : retired_q + 8'd1;
                end
            end
            StIssue: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = StFetch;
                    pc_d    = pc_q + PROG_ADDR_BITS'(1);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    instr_d = instr_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        valid_d = (state_d == StIssue);
        busy_d  = (state_d == StFetch) || (state_d == StIssue);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            retired_q <= '0;
            cnt_q     <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pc          = pc_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_simple_cpu_sequencer.sv
// Directed bench for simple_cpu_sequencer: a cycle table for the main program
// plus hand-written abort, reset, wrap, ignored-input and immediate-HALT runs.
module tb_simple_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [19:0] prog_wdata = '0;
    logic        start = 1'b0;
    logic [3:0]  start_addr = '0;
    logic        abort = 1'b0;
    logic [19:0] instr_out;
    logic        instr_valid;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [7:0]  retired;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    simple_cpu_sequencer #(
        .INSTR_WIDTH      (20),
        .PROG_ADDR_BITS   (4),
        .CYCLES_PER_INSTR (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .start       (start),
        .start_addr  (start_addr),
        .abort       (abort),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .pc          (pc),
        .retired     (retired)
    );

    typedef struct {
        int          cycle;
        logic [19:0] instr;
        logic        valid;
        logic        busy;
        logic        done;
        logic [3:0]  pc;
        logic [7:0]  retired;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Tasks start and end one time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [19:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        step(1);
        prog_we    = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] a);
        start      = 1'b1;
        start_addr = a;
        step(1);
        start      = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [19:0] i, input logic v,
                              input logic b, input logic d, input logic [3:0] p,
                              input logic [7:0] r);
        check({tag, " instr_out"}, 32'(instr_out), 32'(i));
        check({tag, " instr_valid"}, 32'(instr_valid), 32'(v));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " done"}, 32'(done), 32'(d));
        check({tag, " pc"}, 32'(pc), 32'(p));
        check({tag, " retired"}, 32'(retired), 32'(r));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        logic [19:0] prog [7];
        prog = '{20'h47000, 20'h53000, 20'h72001, 20'hD80F0, 20'hCC160, 20'hB80F0, 20'h00000};

        // Main program, N=4: instruction k valid on cycles 2+5k..5+5k.
        tbl[0]  = '{1,  20'h00000, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
        tbl[1]  = '{2,  20'h47000, 1'b1, 1'b1, 1'b0, 4'd0, 8'd1};
        tbl[2]  = '{5,  20'h47000, 1'b1, 1'b1, 1'b0, 4'd0, 8'd1};
        tbl[3]  = '{6,  20'h00000, 1'b0, 1'b1, 1'b0, 4'd1, 8'd1};
        tbl[4]  = '{7,  20'h53000, 1'b1, 1'b1, 1'b0, 4'd1, 8'd2};
        tbl[5]  = '{12, 20'h72001, 1'b1, 1'b1, 1'b0, 4'd2, 8'd3};
        tbl[6]  = '{16, 20'h00000, 1'b0, 1'b1, 1'b0, 4'd3, 8'd3};
        tbl[7]  = '{17, 20'hD80F0, 1'b1, 1'b1, 1'b0, 4'd3, 8'd4};
        tbl[8]  = '{22, 20'hCC160, 1'b1, 1'b1, 1'b0, 4'd4, 8'd5};
        tbl[9]  = '{27, 20'hB80F0, 1'b1, 1'b1, 1'b0, 4'd5, 8'd6};
        tbl[10] = '{30, 20'hB80F0, 1'b1, 1'b1, 1'b0, 4'd5, 8'd6};
        tbl[11] = '{31, 20'h00000, 1'b0, 1'b1, 1'b0, 4'd6, 8'd6};
        tbl[12] = '{32, 20'h00000, 1'b0, 1'b0, 1'b1, 4'd6, 8'd6};
        tbl[13] = '{33, 20'h00000, 1'b0, 1'b0, 1'b0, 4'd6, 8'd6};

        // Reset state
        #3;
        check_outs("reset", 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        #4 rst_n = 1'b1;
        step(1);

        for (int a = 0; a < 16; a++) write_word(4'(a), 20'h0);
        for (int a = 0; a < 7; a++) write_word(4'(a), prog[a]);

        // Table-driven main run
        do_start(4'd0);
        cyc = 1;
        for (int i = 0; i < 14; i++) begin
            while (cyc < tbl[i].cycle) begin
                step(1);
                cyc++;
            end
            @(negedge clk);
            check_outs($sformatf("main c%0d", tbl[i].cycle), tbl[i].instr, tbl[i].valid,
                       tbl[i].busy, tbl[i].done, tbl[i].pc, tbl[i].retired);
        end
        step(1);

        // Abort during the second cycle of instruction 2 (cycle 13)
        do_start(4'd0);
        step(12);
        abort = 1'b1;
        @(negedge clk);
        check("abort pre instr_out", 32'(instr_out), 32'h72001);
        step(1);
        abort = 1'b0;
        @(negedge clk);
        check_outs("abort", 20'h0, 1'b0, 1'b0, 1'b0, 4'd2, 8'd3);
        for (int k = 0; k < 3; k++) begin
            step(1);
            @(negedge clk);
            check($sformatf("abort no done %0d", k), 32'(done | busy), 32'h0);
        end
        step(1);

        // Asynchronous reset mid-ISSUE (cycle 8, instruction 1)
        do_start(4'd0);
        step(7);
        check("prereset pc", 32'(pc), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_outs("async reset", 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        #2 rst_n = 1'b1;
        step(1);

        // PC wrap 15 -> 0 with HALT at word 0
        write_word(4'd14, 20'h47000);
        write_word(4'd15, 20'h53001);
        write_word(4'd0, 20'h00000);
        do_start(4'd14);
        step(1);
        @(negedge clk);
        check_outs("wrap c2", 20'h47000, 1'b1, 1'b1, 1'b0, 4'd14, 8'd1);
        step(5);
        @(negedge clk);
        check_outs("wrap c7", 20'h53001, 1'b1, 1'b1, 1'b0, 4'd15, 8'd2);
        step(4);
        @(negedge clk);
        check_outs("wrap c11", 20'h0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd2);
        step(1);
        @(negedge clk);
        check_outs("wrap c12", 20'h0, 1'b0, 1'b0, 1'b1, 4'd0, 8'd2);
        step(1);

        // start and prog_we while busy are ignored
        write_word(4'd0, 20'h47000);
        write_word(4'd1, 20'h53000);
        write_word(4'd2, 20'h00000);
        for (int run = 0; run < 2; run++) begin
            do_start(4'd0);
            step(2);
            if (run == 0) begin
                start      = 1'b1;
                start_addr = 4'd5;
                prog_we    = 1'b1;
                prog_addr  = 4'd1;
                prog_wdata = 20'hFFFFF;
                step(1);
                start      = 1'b0;
                prog_we    = 1'b0;
            end else begin
                step(1);
            end
            @(negedge clk);
            check($sformatf("ignore r%0d c4 pc", run), 32'(pc), 32'h0);
            check($sformatf("ignore r%0d c4 instr", run), 32'(instr_out), 32'h47000);
            step(3);
            @(negedge clk);
            check($sformatf("ignore r%0d c7 instr", run), 32'(instr_out), 32'h53000);
            step(5);
            @(negedge clk);
            check_outs($sformatf("ignore r%0d c12", run), 20'h0, 1'b0, 1'b0, 1'b1, 4'd2, 8'd2);
            step(1);
        end

        // start together with abort in IDLE stays IDLE
        start      = 1'b1;
        start_addr = 4'd0;
        abort      = 1'b1;
        step(1);
        start      = 1'b0;
        abort      = 1'b0;
        @(negedge clk);
        check_outs("start+abort", 20'h0, 1'b0, 1'b0, 1'b0, 4'd2, 8'd2);
        step(1);
        @(negedge clk);
        check("start+abort later busy", 32'(busy), 32'h0);
        step(1);

        // Immediate HALT at start_addr
        do_start(4'd2);
        @(negedge clk);
        check_outs("halt c1", 20'h0, 1'b0, 1'b1, 1'b0, 4'd2, 8'd0);
        step(1);
        @(negedge clk);
        check_outs("halt c2", 20'h0, 1'b0, 1'b0, 1'b1, 4'd2, 8'd0);
        step(1);
        @(negedge clk);
        check_outs("halt c3", 20'h0, 1'b0, 1'b0, 1'b0, 4'd2, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
